// File: rtl/dm_access_ctrl_pkg.sv
// rtl/dm_access_ctrl_pkg.sv - opcodes, FSM states and decode helpers for the data-memory sequencer
package dm_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    // Unknown opcodes count as faults so they never touch memory.
    function automatic logic access_fault(input logic [5:0] op, input logic [1:0] sel);
        case (op)
            OP_LB, OP_LBU, OP_SB: access_fault = 1'b0;
            OP_LH, OP_LHU, OP_SH: access_fault = sel[0];
            OP_LW, OP_SW:         access_fault = |sel;
            default:              access_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_ctrl_st_merge.sv
// rtl/dm_access_ctrl_st_merge.sv - inserts sub-word store data into the word read back from memory
module dm_access_ctrl_st_merge
    import dm_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  sel,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] merged
);

    always_comb begin
        merged = rdata;
        if (op == OP_SB) begin
            merged[{3'b000, sel} * 8 +: 8] = wdata[7:0];
        end else if (op == OP_SH) begin
            if (sel[1]) begin
                merged[31:16] = wdata[15:0];
            end else begin
                merged[15:0] = wdata[15:0];
            end
        end else begin
            merged = wdata;
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - load/store memory handshake sequencer with read-modify-write and DMR latch
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              align_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] dmr_data,
    output logic [1:0]        dmr_sel,
    output logic [5:0]        dmr_op
);

    state_t            state, state_nx;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wword_q;
    logic [DATA_W-1:0] merged;
    logic              accept;

    assign accept = (state == ST_IDLE) && req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (access_fault(op, addr[1:0])) begin
                        state_nx = ST_ERR;
                    end else if (op == OP_SW) begin
                        state_nx = ST_WR;
                    end else begin
                        state_nx = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    if (is_load(op_q)) begin
                        state_nx = ST_DONE;
                    end else if (op_q == OP_SB || op_q == OP_SH) begin
                        state_nx = ST_WR;
                    end
                end
            end
            ST_WR:   if (mem_ready) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE) || (state == ST_ERR);
        align_err = (state == ST_ERR);
        mem_req   = (state == ST_RD) || (state == ST_WR);
        mem_we    = (state == ST_WR);
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wword_q;
    end

    dm_access_ctrl_st_merge u_st_merge (
        .op     (op_q),
        .sel    (addr_q[1:0]),
        .rdata  (mem_rdata),
        .wdata  (wdata_q),
        .merged (merged)
    );

    // wword_q is loaded with raw wdata on accept so SW can go straight to WR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wword_q  <= '0;
            dmr_data <= '0;
            dmr_sel  <= '0;
            dmr_op   <= '0;
        end else begin
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                wword_q <= wdata;
                if (is_load(op) && !access_fault(op, addr[1:0])) begin
                    dmr_op  <= op;
                    dmr_sel <= addr[1:0];
                end
            end
            if (state == ST_RD && mem_ready) begin
                if (is_load(op_q)) begin
                    dmr_data <= mem_rdata;
                end else begin
                    wword_q <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - directed self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, align_err, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dmr_data;
    logic [1:0]  dmr_sel;
    logic [5:0]  dmr_op;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd_word = 32'h0;
    int          wait_cfg = 0;
    logic        hold_low = 1'b0;
    int          ctr = 0;
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, stab_err = 0, req_cyc = 0;
    logic [31:0] last_waddr = 32'h0, last_wdata = 32'h0, last_raddr = 32'h0;
    logic        held = 1'b0, h_we = 1'b0;
    logic [31:0] h_addr = 32'h0, h_wdata = 32'h0;

    dm_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .align_err (align_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dmr_data  (dmr_data),
        .dmr_sel   (dmr_sel),
        .dmr_op    (dmr_op)
    );

    always #5 clk = ~clk;

    assign mem_rdata = rd_word;
    assign mem_ready = mem_req && !hold_low && (ctr >= wait_cfg);

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end else begin
                rd_cnt     <= rd_cnt + 1;
                last_raddr <= mem_addr;
            end
        end
        if (mem_req && held && (mem_addr !== h_addr || mem_we !== h_we || (mem_we && mem_wdata !== h_wdata)))
            stab_err <= stab_err + 1;
        held    <= mem_req && !mem_ready;
        h_addr  <= mem_addr;
        h_we    <= mem_we;
        h_wdata <= mem_wdata;
        if (mem_req) req_cyc <= req_cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (!mem_req || mem_ready) ctr <= 0;
        else ctr <= ctr + 1;
    end

    task automatic do_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                             output int cycles, output logic aerr);
        op = o; addr = a; wdata = w; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        cycles = 1;
        while (!done && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        aerr = align_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, align_err, mem_req, mem_we} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
            || dmr_data !== 32'h0 || dmr_sel !== 2'b0 || dmr_op !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b aerr=%b req=%b we=%b addr=%h wd=%h dmr=%h/%b/%b exp all zero",
                     busy, done, align_err, mem_req, mem_we, mem_addr, mem_wdata, dmr_data, dmr_sel, dmr_op);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        int cyc; logic ae; int r0;
        rd_word = 32'h80AB_CD12; wait_cfg = 0; r0 = rd_cnt;
        do_access(6'b100000, 32'h0000_1003, 32'h0, cyc, ae);
        checks++;
        if (cyc !== 2 || ae !== 1'b0) begin failures++; $display("FAIL lb_latency got=%0d aerr=%b exp=2 aerr=0", cyc, ae); end
        checks++;
        if (dmr_data !== 32'h80AB_CD12 || dmr_sel !== 2'b11 || dmr_op !== 6'b100000) begin
            failures++; $display("FAIL lb_dmr got=%h/%b/%b exp=80abcd12/11/100000", dmr_data, dmr_sel, dmr_op);
        end
        checks++;
        if (rd_cnt - r0 !== 1 || last_raddr !== 32'h0000_1000 || mem_addr !== 32'h0000_1000) begin
            failures++; $display("FAIL lb_read got reads=%0d raddr=%h mem_addr=%h exp 1 00001000", rd_cnt - r0, last_raddr, mem_addr);
        end
    endtask

    task automatic test_sb();
        int cyc; logic ae; int r0, w0;
        rd_word = 32'h1122_3344; wait_cfg = 0; r0 = rd_cnt; w0 = wr_cnt;
        do_access(6'b101000, 32'h0000_2001, 32'hFFFF_FF5A, cyc, ae);
        checks++;
        if (cyc !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", cyc); end
        checks++;
        if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1 || last_waddr !== 32'h0000_2000 || last_wdata !== 32'h1122_5A44) begin
            failures++; $display("FAIL sb_write got rd=%0d wr=%0d addr=%h data=%h exp 1 1 00002000 11225a44",
                                 rd_cnt - r0, wr_cnt - w0, last_waddr, last_wdata);
        end
        checks++;
        if (dmr_data !== 32'h80AB_CD12 || dmr_sel !== 2'b11 || dmr_op !== 6'b100000) begin
            failures++; $display("FAIL sb_dmr_hold got=%h/%b/%b exp=80abcd12/11/100000", dmr_data, dmr_sel, dmr_op);
        end
    endtask

    task automatic test_sh_wait();
        int cyc; logic ae; int s0, w0;
        rd_word = 32'h1122_3344; wait_cfg = 2; s0 = stab_err; w0 = wr_cnt;
        do_access(6'b101001, 32'h0000_2002, 32'h0000_BEEF, cyc, ae);
        checks++;
        if (cyc !== 7) begin failures++; $display("FAIL sh_latency got=%0d exp=7", cyc); end
        checks++;
        if (wr_cnt - w0 !== 1 || last_waddr !== 32'h0000_2000 || last_wdata !== 32'hBEEF_3344) begin
            failures++; $display("FAIL sh_write got wr=%0d addr=%h data=%h exp 1 00002000 beef3344", wr_cnt - w0, last_waddr, last_wdata);
        end
        checks++;
        if (stab_err - s0 !== 0) begin failures++; $display("FAIL sh_stable got=%0d exp=0", stab_err - s0); end
        wait_cfg = 0;
    endtask

    task automatic test_errors();
        int cyc; logic ae; int q0;
        q0 = req_cyc;
        do_access(6'b100011, 32'h0000_3002, 32'h0, cyc, ae);
        checks++;
        if (cyc !== 1 || ae !== 1'b1) begin failures++; $display("FAIL lw_misalign got cyc=%0d aerr=%b exp cyc=1 aerr=1", cyc, ae); end
        do_access(6'b000000, 32'h0000_3002, 32'h0, cyc, ae);
        checks++;
        if (cyc !== 1 || ae !== 1'b1) begin failures++; $display("FAIL illegal_op got cyc=%0d aerr=%b exp cyc=1 aerr=1", cyc, ae); end
        checks++;
        if (req_cyc - q0 !== 0 || dmr_data !== 32'h80AB_CD12 || dmr_sel !== 2'b11 || dmr_op !== 6'b100000) begin
            failures++; $display("FAIL err_side_effects got memreq_cycles=%0d dmr=%h/%b/%b exp 0 80abcd12/11/100000",
                                 req_cyc - q0, dmr_data, dmr_sel, dmr_op);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; int d0, w0, r0;
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt; cyc = 0;
        op = 6'b101011; addr = 32'h0000_4000; wdata = 32'hDEAD_BEEF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL sw_busy got busy=%b we=%b exp 1 1", busy, mem_we); end
        req = 1'b1; op = 6'b101011; addr = 32'h0000_5000; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0;
        cyc++;
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL sw_latency got done=%b at cycle %0d exp done=1", done, cyc); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0 || last_waddr !== 32'h0000_4000
            || last_wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sw_single got dones=%0d wr=%0d rd=%0d addr=%h data=%h exp 1 1 0 00004000 deadbeef",
                                 done_cnt - d0, wr_cnt - w0, rd_cnt - r0, last_waddr, last_wdata);
        end
    endtask

    task automatic test_reset_abort();
        int cyc; logic ae; int d0;
        hold_low = 1'b1; d0 = done_cnt;
        op = 6'b100011; addr = 32'h0000_5000; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL abort_pending got busy=%b req=%b exp 1 1", busy, mem_req); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; hold_low = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_idle got busy=%b req=%b done=%b exp 0 0 0", busy, mem_req, done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
        rd_word = 32'h1234_5678;
        do_access(6'b100011, 32'h0000_5004, 32'h0, cyc, ae);
        checks++;
        if (cyc !== 2 || ae !== 1'b0 || dmr_data !== 32'h1234_5678 || dmr_sel !== 2'b00 || dmr_op !== 6'b100011) begin
            failures++; $display("FAIL lw_after_reset got cyc=%0d aerr=%b dmr=%h/%b/%b exp 2 0 12345678/00/100011",
                                 cyc, ae, dmr_data, dmr_sel, dmr_op);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sb();
        test_sh_wait();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Data-memory access sequencer for the multicycle datapath, directly upstream of the load-data extender.
- Runs the word-wide memory handshake for all load and store opcodes.
- Does read-modify-write for SB/SH, since the memory has no byte enables.
- Latches the loaded word plus its opcode and byte offset into the DMR register that the extender consumes.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width; fixed at 32 for this datapath.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- req  in  1  access request from the controller; sampled in IDLE only
- op  in  6  instr[31:26]
- addr  in  32  byte address (ALU output)
- wdata  in  32  store data (rt)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the access completes
- align_err  out  1  one-cycle pulse, coincident with done, for a misaligned or illegal op
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2],2'b00} of the latched address
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid when mem_ready=1 on a read
- mem_ready  in  1  memory accept/complete; may be combinational with mem_req
- dmr_data  out  32  registered read word, to the extender din
- dmr_sel  out  2  latched addr[1:0], to the extender control
- dmr_op  out  6  latched op, to the extender OP

Behaviour:
- Reset (sync, rst_n=0 at a clk edge): state IDLE, and all of the following are 0: busy, done, align_err, mem_req, mem_we, mem_addr, mem_wdata, dmr_data, dmr_sel, dmr_op.
- Reset mid-operation aborts the access immediately: mem_req drops the next cycle and no done pulse is produced.
- Opcodes, in the shared package: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- IDLE with req=1:
  - Latch op, addr, wdata.
  - On a load, also latch dmr_op=op and dmr_sel=addr[1:0].
  - Check alignment:
    - LH/LHU/SH require addr[0]=0.
    - LW/SW require addr[1:0]=00.
    - Any non-listed op is illegal.
  - Error → ERR. SW → WR. All other legal ops → RD.
- IDLE with req=0: stay. req while busy is ignored and has no effect.
- RD: mem_req=1, mem_we=0.
  - On mem_ready=1, capture mem_rdata.
  - Load: dmr_data←rdata, go to DONE.
  - SB/SH: merge the word, go to WR.
  - Otherwise stay in RD.
- Merge rules:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - The other lanes keep the read data.
- WR: mem_req=1, mem_we=1, mem_wdata = merged word (SW: wdata). On mem_ready=1 go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and align_err=1 for one cycle, then IDLE. No memory request is issued. dmr_* are unchanged.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- mem_req is low in IDLE, DONE and ERR.
- dmr_data/dmr_sel/dmr_op hold until the next completed load; stores never modify them.
- Latency from the req-accept edge, zero-wait memory: load 2 cycles to done, SW 2, SB/SH 3, error 1.
- Each memory wait cycle adds 1.
- States: IDLE, RD, WR, DONE, ERR. State encoding is defined in the package.

Decomposition:
- Shared package/include: the opcode defines listed above (already shared with the instruction decoder and extender) plus the state encodings.
- Sub-module st_merge: combinational; inputs op, sel[1:0], rdata, wdata; output merged word.

Test Plan:
- LB, addr=0x1003, mem word 0x80AB_CD12, zero-wait memory → done 2 cycles after accept; dmr_data=0x80ABCD12, dmr_sel=11, dmr_op=100000; mem_addr=0x1000, mem_we=0.
- SB, addr=0x2001, wdata=0xFFFF_FF5A, read word 0x1122_3344 → a read, then one write of 0x1122_5A44 to 0x2000; done at cycle 3; dmr_* unchanged.
- SH, addr=0x2002, wdata=0x0000_BEEF, read 0x1122_3344, mem_ready delayed 2 cycles on both the read and the write → write data 0xBEEF_3344; done at cycle 7; mem_req held steady during the waits.
- LW, addr=0x3002 → align_err=done=1 one cycle after accept; mem_req never asserted. Repeat with op=000000 → same result.
- SW, addr=0x4000, wdata=0xDEAD_BEEF → a single write; done 2 cycles after accept. A second req pulsed while busy=1 is ignored, giving exactly one done.
- LW with mem_ready held low, rst_n=0 for one cycle → next cycle: IDLE, mem_req=0, busy=0, no done. A following LW completes normally.
